// File: rtl/button_debounce_multi_if.sv
// Signal bundle for button_debounce_multi: raw button inputs plus every debounced
// level and event-pulse output.
interface button_debounce_multi_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] button_raw;
    logic [CHANNELS-1:0] button_state;
    logic [CHANNELS-1:0] button_just_went_active;
    logic [CHANNELS-1:0] button_just_went_inactive;
    logic [CHANNELS-1:0] button_just_changed;
    logic [CHANNELS-1:0] button_long_press;
    logic [CHANNELS-1:0] button_repeat;

    modport master (
        output button_raw,
        input  button_state,
        input  button_just_went_active,
        input  button_just_went_inactive,
        input  button_just_changed,
        input  button_long_press,
        input  button_repeat
    );

    modport slave (
        input  button_raw,
        output button_state,
        output button_just_went_active,
        output button_just_went_inactive,
        output button_just_changed,
        output button_long_press,
        output button_repeat
    );
endinterface

// File: rtl/button_debounce_multi.sv
// Multi-channel synchroniser, debouncer and edge detector with long-press and
// optional auto-repeat. Every channel is an independent copy of the same pipeline.
module button_debounce_multi #(
    parameter int    CHANNELS                 = 4,
    parameter int    METASTABLE_CLOCK_PERIODS = 3,
    parameter int    DEBOUNCE_CLOCK_PERIODS   = 20,
    parameter int    LONG_PRESS_CLOCK_PERIODS = 1000,
    parameter int    REPEAT_CLOCK_PERIODS     = 200,
    parameter int    REPEAT_ENABLE            = 0,
    parameter string POLARITY                 = "HIGH"
) (
    input  logic                    clock,
    input  logic                    reset,
    button_debounce_multi_if.slave  bus
);

    localparam int DB_W   = $clog2(DEBOUNCE_CLOCK_PERIODS);
    localparam int HOLD_W = $clog2(LONG_PRESS_CLOCK_PERIODS + REPEAT_CLOCK_PERIODS + 1);
    localparam int SYNC_W = METASTABLE_CLOCK_PERIODS;

    localparam logic              INVERT      = (POLARITY == "LOW");
    localparam logic              REPEAT_ON   = (REPEAT_ENABLE != 0);
    localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_CLOCK_PERIODS - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST   = HOLD_W'(LONG_PRESS_CLOCK_PERIODS - 1);
    localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_CLOCK_PERIODS - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX    = '1;

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        LONG
    } press_state_t;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_channel
        logic [SYNC_W-1:0] sync_chain;
        logic              synced;
        logic [DB_W-1:0]   db_count;
        logic [HOLD_W-1:0] hold_count;
        logic [HOLD_W-1:0] hold_next;
        logic              state_q;
        logic              went_active_q;
        logic              went_inactive_q;
        logic              changed_q;
        logic              long_q;
        logic              repeat_q;
        logic              accept;
        logic              accept_press;
        logic              accept_release;
        logic              fire_long;
        logic              fire_repeat;
        press_state_t      fsm_state;
        press_state_t      fsm_next;

        // Reset parks the chain at the inactive level so a held input is seen as a fresh press.
        always_ff @(posedge clock) begin
            if (!reset) begin
                sync_chain <= {SYNC_W{INVERT}};
            end else begin
                sync_chain <= {sync_chain[SYNC_W-2:0], bus.button_raw[ch]};
            end
        end

        assign synced         = sync_chain[SYNC_W-1] ^ INVERT;
        assign accept         = (synced != state_q) && (db_count == DB_LAST);
        assign accept_press   = accept && !state_q;
        assign accept_release = accept && state_q;

        always_ff @(posedge clock) begin
            if (!reset) begin
                db_count <= '0;
                state_q  <= 1'b0;
            end else if (synced == state_q || accept) begin
                db_count <= '0;
                if (accept) begin
                    state_q <= ~state_q;
                end
            end else begin
                db_count <= db_count + DB_W'(1);
            end
        end

        // An accepted release takes priority over a long-press or repeat on the same edge.
        always_comb begin
            fsm_next    = fsm_state;
            fire_long   = 1'b0;
            fire_repeat = 1'b0;
            case (fsm_state)
                IDLE: begin
                    if (accept_press) begin
                        fsm_next = HELD;
                    end
                end
                HELD: begin
                    if (accept_release) begin
                        fsm_next = IDLE;
                    end else if (hold_count == LONG_LAST) begin
                        fsm_next  = LONG;
                        fire_long = 1'b1;
                    end
                end
                LONG: begin
                    if (accept_release) begin
                        fsm_next = IDLE;
                    end else if (REPEAT_ON && hold_count == REPEAT_LAST) begin
                        fire_repeat = 1'b1;
                    end
                end
                default: fsm_next = IDLE;
            endcase
        end

        always_comb begin
            hold_next = hold_count + HOLD_W'(1);
            if (accept || !state_q || fire_long || fire_repeat) begin
                hold_next = '0;
            end else if (fsm_state == LONG && !REPEAT_ON && hold_count == HOLD_MAX) begin
                hold_next = hold_count;
            end
        end

        always_ff @(posedge clock) begin
            if (!reset) begin
                fsm_state       <= IDLE;
                hold_count      <= '0;
                went_active_q   <= 1'b0;
                went_inactive_q <= 1'b0;
                changed_q       <= 1'b0;
                long_q          <= 1'b0;
                repeat_q        <= 1'b0;
            end else begin
                fsm_state       <= fsm_next;
                hold_count      <= hold_next;
                went_active_q   <= accept_press;
                went_inactive_q <= accept_release;
                changed_q       <= accept;
                long_q          <= fire_long;
                repeat_q        <= fire_repeat;
            end
        end

        assign bus.button_state[ch]              = state_q;
        assign bus.button_just_went_active[ch]   = went_active_q;
        assign bus.button_just_went_inactive[ch] = went_inactive_q;
        assign bus.button_just_changed[ch]       = changed_q;
        assign bus.button_long_press[ch]         = long_q;
        assign bus.button_repeat[ch]             = repeat_q;
    end

endmodule

// File: tb/tb_button_debounce_multi.sv
// Scoreboard bench for button_debounce_multi: three instances (repeat on, repeat off,
// active-low) driven by directed vectors; monitors pop expected events as pulses appear.
module tb_button_debounce_multi;

    typedef struct packed {
        int         cyc;
        logic [1:0] st;
        logic [1:0] act;
        logic [1:0] inact;
        logic [1:0] chg;
        logic [1:0] lng;
        logic [1:0] rpt;
    } ev_t;

    logic clock;
    logic reset_a;
    logic reset_b;
    logic reset_c;
    int   cyc;
    int   checks;
    int   errors;
    ev_t  q_a[$];
    ev_t  q_b[$];
    ev_t  q_c[$];

    button_debounce_multi_if #(.CHANNELS(2)) bus_a ();
    button_debounce_multi_if #(.CHANNELS(2)) bus_b ();
    button_debounce_multi_if #(.CHANNELS(2)) bus_c ();

    button_debounce_multi #(
        .CHANNELS(2), .METASTABLE_CLOCK_PERIODS(3), .DEBOUNCE_CLOCK_PERIODS(10),
        .LONG_PRESS_CLOCK_PERIODS(50), .REPEAT_CLOCK_PERIODS(20),
        .REPEAT_ENABLE(1), .POLARITY("HIGH")
    ) dut_a (.clock(clock), .reset(reset_a), .bus(bus_a));

    button_debounce_multi #(
        .CHANNELS(2), .METASTABLE_CLOCK_PERIODS(3), .DEBOUNCE_CLOCK_PERIODS(10),
        .LONG_PRESS_CLOCK_PERIODS(50), .REPEAT_CLOCK_PERIODS(20),
        .REPEAT_ENABLE(0), .POLARITY("HIGH")
    ) dut_b (.clock(clock), .reset(reset_b), .bus(bus_b));

    button_debounce_multi #(
        .CHANNELS(2), .METASTABLE_CLOCK_PERIODS(3), .DEBOUNCE_CLOCK_PERIODS(10),
        .LONG_PRESS_CLOCK_PERIODS(50), .REPEAT_CLOCK_PERIODS(20),
        .REPEAT_ENABLE(0), .POLARITY("LOW")
    ) dut_c (.clock(clock), .reset(reset_c), .bus(bus_c));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    function automatic ev_t mk(input int c, input logic [1:0] st, input logic [1:0] act,
                               input logic [1:0] inact, input logic [1:0] chg,
                               input logic [1:0] lng, input logic [1:0] rpt);
        ev_t e;
        e.cyc = c; e.st = st; e.act = act; e.inact = inact;
        e.chg = c == c ? chg : chg; e.lng = lng; e.rpt = rpt;
        return e;
    endfunction

    task automatic compare_event(input string name, input ev_t exp, input ev_t got);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL event_%s: got cyc=%0d st=%b act=%b inact=%b chg=%b long=%b rep=%b, expected cyc=%0d st=%b act=%b inact=%b chg=%b long=%b rep=%b",
                     name, got.cyc, got.st, got.act, got.inact, got.chg, got.lng, got.rpt,
                     exp.cyc, exp.st, exp.act, exp.inact, exp.chg, exp.lng, exp.rpt);
        end
    endtask

    task automatic report_unexpected(input string name, input ev_t got);
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_%s: got pulse at cyc=%0d st=%b act=%b inact=%b chg=%b long=%b rep=%b, expected no pulse",
                 name, got.cyc, got.st, got.act, got.inact, got.chg, got.lng, got.rpt);
    endtask

    task automatic check_output(input string name, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) @(negedge clock);
    endtask

    // Monitors: any pulse on an instance consumes the next expected event for it.
    always @(negedge clock) begin : mon_a
        ev_t got;
        got = mk(cyc, bus_a.button_state, bus_a.button_just_went_active, bus_a.button_just_went_inactive,
                 bus_a.button_just_changed, bus_a.button_long_press, bus_a.button_repeat);
        if ((got.act | got.inact | got.chg | got.lng | got.rpt) != 2'b00) begin
            if (q_a.size() == 0) report_unexpected("a", got);
            else compare_event("a", q_a.pop_front(), got);
        end
    end

    always @(negedge clock) begin : mon_b
        ev_t got;
        got = mk(cyc, bus_b.button_state, bus_b.button_just_went_active, bus_b.button_just_went_inactive,
                 bus_b.button_just_changed, bus_b.button_long_press, bus_b.button_repeat);
        if ((got.act | got.inact | got.chg | got.lng | got.rpt) != 2'b00) begin
            if (q_b.size() == 0) report_unexpected("b", got);
            else compare_event("b", q_b.pop_front(), got);
        end
    end

    always @(negedge clock) begin : mon_c
        ev_t got;
        got = mk(cyc, bus_c.button_state, bus_c.button_just_went_active, bus_c.button_just_went_inactive,
                 bus_c.button_just_changed, bus_c.button_long_press, bus_c.button_repeat);
        if ((got.act | got.inact | got.chg | got.lng | got.rpt) != 2'b00) begin
            if (q_c.size() == 0) report_unexpected("c", got);
            else compare_event("c", q_c.pop_front(), got);
        end
    end

    task automatic apply_stimulus_ab(input logic [1:0] value);
        bus_a.button_raw = value;
        bus_b.button_raw = value;
    endtask

    initial begin : stimulus
        int t;
        int u;
        int e;
        cyc    = 0;
        checks = 0;
        errors = 0;
        reset_a = 1'b0;
        reset_b = 1'b0;
        reset_c = 1'b0;
        bus_a.button_raw = 2'b00;
        bus_b.button_raw = 2'b00;
        bus_c.button_raw = 2'b11;

        repeat (3) @(negedge clock);
        check_output("reset_a", {bus_a.button_state, bus_a.button_just_went_active, bus_a.button_just_went_inactive,
                                 bus_a.button_just_changed, bus_a.button_long_press, bus_a.button_repeat}, 12'b0);
        check_output("reset_b", {bus_b.button_state, bus_b.button_just_went_active, bus_b.button_just_went_inactive,
                                 bus_b.button_just_changed, bus_b.button_long_press, bus_b.button_repeat}, 12'b0);
        check_output("reset_c", {bus_c.button_state, bus_c.button_just_went_active, bus_c.button_just_went_inactive,
                                 bus_c.button_just_changed, bus_c.button_long_press, bus_c.button_repeat}, 12'b0);
        reset_a = 1'b1;
        reset_b = 1'b1;
        reset_c = 1'b1;
        repeat (30) @(negedge clock);
        check_output("low_idle_state_c", {10'b0, bus_c.button_state}, 12'b0);

        // Clean press and release on ch0 of instance a only.
        t = cyc;
        bus_a.button_raw = 2'b01;
        q_a.push_back(mk(t + 13, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00));
        wait_to(t + 20);
        check_output("press_level_a", {10'b0, bus_a.button_state}, {10'b0, 2'b01});
        bus_a.button_raw = 2'b00;
        q_a.push_back(mk(t + 33, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00));
        wait_to(t + 45);

        // Bounce then long hold on instances a (repeat) and b (no repeat).
        t = cyc;
        for (int seg = 0; seg < 10; seg++) begin
            apply_stimulus_ab((seg % 2 == 0) ? 2'b01 : 2'b00);
            repeat (4) @(negedge clock);
        end
        apply_stimulus_ab(2'b01);
        e = cyc + 13;
        q_a.push_back(mk(e, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00));
        q_b.push_back(mk(e, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00));
        q_a.push_back(mk(e + 50, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00));
        q_b.push_back(mk(e + 50, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00));
        for (int k = 0; k < 7; k++) begin
            q_a.push_back(mk(e + 70 + 20 * k, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01));
        end
        wait_to(e + 187);
        apply_stimulus_ab(2'b00);
        q_a.push_back(mk(e + 200, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00));
        q_b.push_back(mk(e + 200, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00));
        wait_to(e + 215);

        // Reset during ch0 debounce while ch1 is already held.
        t = cyc;
        bus_a.button_raw = 2'b10;
        q_a.push_back(mk(t + 13, 2'b10, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00));
        wait_to(t + 20);
        u = cyc;
        bus_a.button_raw = 2'b11;
        wait_to(u + 8);
        reset_a = 1'b0;
        @(negedge clock);
        check_output("mid_reset_a", {bus_a.button_state, bus_a.button_just_went_active, bus_a.button_just_went_inactive,
                                     bus_a.button_just_changed, bus_a.button_long_press, bus_a.button_repeat}, 12'b0);
        reset_a = 1'b1;
        q_a.push_back(mk(u + 22, 2'b11, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00));
        wait_to(u + 40);
        bus_a.button_raw = 2'b00;
        q_a.push_back(mk(u + 53, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00));
        wait_to(u + 60);

        // ch0 press and ch1 release accepted on the same edge.
        t = cyc;
        bus_a.button_raw = 2'b10;
        q_a.push_back(mk(t + 13, 2'b10, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00));
        wait_to(t + 20);
        bus_a.button_raw = 2'b01;
        q_a.push_back(mk(t + 33, 2'b01, 2'b01, 2'b10, 2'b11, 2'b00, 2'b00));
        wait_to(t + 40);
        bus_a.button_raw = 2'b00;
        q_a.push_back(mk(t + 53, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00));
        wait_to(t + 60);

        // Release accepted on exactly the edge the long press would fire.
        t = cyc;
        bus_a.button_raw = 2'b01;
        q_a.push_back(mk(t + 13, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00));
        wait_to(t + 50);
        bus_a.button_raw = 2'b00;
        q_a.push_back(mk(t + 63, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00));
        wait_to(t + 70);

        // Active-low instance: driving ch0 low is a press.
        t = cyc;
        bus_c.button_raw = 2'b10;
        q_c.push_back(mk(t + 13, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00));
        wait_to(t + 20);
        check_output("low_press_level_c", {10'b0, bus_c.button_state}, {10'b0, 2'b01});
        bus_c.button_raw = 2'b11;
        q_c.push_back(mk(t + 33, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00));
        wait_to(t + 45);

        check_output("pending_a", 12'(q_a.size()), 12'd0);
        check_output("pending_b", 12'(q_b.size()), 12'd0);
        check_output("pending_c", 12'(q_c.size()), 12'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_debounce_multi.md
# button_debounce_multi

Multi-channel successor to the single-button debouncer: synchronises, debounces and edge-detects CHANNELS independent raw inputs (buttons, switches, slow async strobes) in one clock domain. It adds per-build input polarity, long-press detection and optional auto-repeat. It sits between board-level GPIO inputs and control logic, and replaces per-button debouncer instances in new top levels.

## Interface
- CHANNELS, 4: number of independent inputs; 1..32.
- METASTABLE_CLOCK_PERIODS, 3: synchroniser flop depth; minimum 2.
- DEBOUNCE_CLOCK_PERIODS, 20: consecutive cycles of a new level required before it is accepted; minimum 2.
- LONG_PRESS_CLOCK_PERIODS, 1000: cycles held active, after acceptance, before a long-press pulse.
- REPEAT_CLOCK_PERIODS, 200: auto-repeat interval after a long press.
- REPEAT_ENABLE, 0: 1 enables auto-repeat pulses.
- POLARITY, "HIGH": "HIGH" means raw=1 is active; "LOW" means raw=0 is active. Applies to all channels.
- clock  input  1  single clock for all logic.
- reset  input  1  synchronous, active-low (reset==0 resets on the rising clock edge).
- button_raw  input  CHANNELS  asynchronous raw inputs.
- button_state  output  CHANNELS  debounced level, normalised so 1 means active.
- button_just_went_active  output  CHANNELS  1-cycle pulse on accepted press.
- button_just_went_inactive  output  CHANNELS  1-cycle pulse on accepted release.
- button_just_changed  output  CHANNELS  OR of the two pulses above.
- button_long_press  output  CHANNELS  1-cycle pulse, once per press.
- button_repeat  output  CHANNELS  1-cycle pulse at each repeat interval.

## Operation
- Each channel is fully independent; channels share no state.
- Synchroniser: METASTABLE_CLOCK_PERIODS-deep flop chain. Its last stage XOR the polarity inversion gives `synced` (1 = active).
- Debounce counter has width $clog2(DEBOUNCE_CLOCK_PERIODS).
  - synced == button_state: counter is cleared.
  - Otherwise the counter increments. If it already equals DEBOUNCE_CLOCK_PERIODS-1, button_state toggles, the matching edge pulse and button_just_changed assert, and the counter clears.
  - A single agreeing cycle restarts the count, so glitches shorter than DEBOUNCE_CLOCK_PERIODS never propagate.
- Hold counter has width $clog2(LONG_PRESS_CLOCK_PERIODS+REPEAT_CLOCK_PERIODS+1).
  - Cleared on every accepted edge and while button_state==0.
  - Increments each cycle while button_state==1.
- Long-press FSM per channel: IDLE -> HELD on accepted press; HELD -> LONG when hold reaches LONG_PRESS_CLOCK_PERIODS.
  - On the HELD -> LONG transition, button_long_press pulses and the hold counter clears.
  - In LONG with REPEAT_ENABLE=1: each time hold reaches REPEAT_CLOCK_PERIODS, button_repeat pulses and hold clears.
  - In LONG with REPEAT_ENABLE=0: hold saturates; no further pulses.
  - Any state -> IDLE on accepted release.
- A release accepted on the same edge a long-press or repeat would fire wins: only button_just_went_inactive pulses.
- Reset (reset==0 at an edge) sets all of the following to 0 on that edge, including mid-debounce or mid-hold:
  - synchroniser stages (to the inactive level after polarity);
  - counters and FSM state (FSM to IDLE);
  - all outputs.
- A raw input that is already active when reset releases is accepted as a press after the normal latency.

## Timing
- Edge 1 is the first rising edge that samples the new raw level.
- Accepted press or release: button_state and the edge pulse update at edge METASTABLE_CLOCK_PERIODS+DEBOUNCE_CLOCK_PERIODS.
  - Example: defaults 3+20 give edge 23.
- Long press: pulses LONG_PRESS_CLOCK_PERIODS edges after the just_went_active edge.
- Repeats: the first is REPEAT_CLOCK_PERIODS edges after long_press, then every REPEAT_CLOCK_PERIODS edges.
- All pulses are exactly one cycle wide. All outputs are registered; no combinational path from button_raw.

## Test plan
- Use CHANNELS=2, METASTABLE=3, DEBOUNCE=10, LONG=50, REPEAT=20, POLARITY="HIGH" unless stated.
- Clean press on ch0 only, raw 0->1 and held:
  - button_state[0] rises and just_went_active[0] and just_changed[0] pulse at edge 13;
  - ch1 stays all-zero.
- Bounce: raw[0] toggles every 4 cycles for 40 cycles, then holds 1:
  - no pulses during the bounce;
  - single press accepted 13 edges after the final 0->1.
- Long press and repeat, REPEAT_ENABLE=1, hold 200 cycles after acceptance:
  - long_press at +50;
  - repeat at +70, +90, … +190 (7 pulses);
  - release pulses just_went_inactive once.
  - Repeat the run with REPEAT_ENABLE=0: zero repeat pulses.
- POLARITY="LOW": raw held 1 through reset gives no press. raw 1->0 gives a press at edge 13; button_state==1 while raw==0.
- Reset mid-debounce (reset=0 at count 5 for 1 cycle, raw held active):
  - every output is 0 on the next cycle;
  - the press is re-accepted 13 edges after reset deasserts.
- Simultaneous edges: ch0 press and ch1 release on the same cycle produce independent pulses on the same edge; no cross-channel interaction.
